// File: rtl/pulse_train_generator.sv
// Programmable pulse-train source: N pulses of H high cycles separated by max(L,1) low cycles.
// Busy/done give a request/completion handshake; all outputs are registered.
module pulse_train_generator #(
    parameter int WIDTH_W = 4,
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH_W-1:0] high_len,
    input  logic [WIDTH_W-1:0] low_len,
    input  logic [COUNT_W-1:0] pulse_count,
    output logic               pulse_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HIGH   = 2'd1,
        ST_LOW    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [WIDTH_W-1:0] W_ZERO = WIDTH_W'(0);
    localparam logic [WIDTH_W-1:0] W_ONE  = WIDTH_W'(1);
    localparam logic [COUNT_W-1:0] C_ZERO = COUNT_W'(0);
    localparam logic [COUNT_W-1:0] C_ONE  = COUNT_W'(1);

    state_t             state_q,     state_d;
    logic [WIDTH_W-1:0] high_len_q,  high_len_d;
    logic [WIDTH_W-1:0] low_len_q,   low_len_d;
    logic [COUNT_W-1:0] pulses_q,    pulses_d;
    logic [WIDTH_W-1:0] high_cnt_q,  high_cnt_d;
    logic [WIDTH_W-1:0] low_cnt_q,   low_cnt_d;
    logic               pulse_out_q, pulse_out_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;

    // Next-state, counter and output decode.
    always_comb begin
        state_d    = state_q;
        high_len_d = high_len_q;
        low_len_d  = low_len_q;
        pulses_d   = pulses_q;
        high_cnt_d = high_cnt_q;
        low_cnt_d  = low_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    high_len_d = high_len;
                    // Zero gap is clamped so consecutive pulses never merge.
                    low_len_d  = (low_len == W_ZERO) ? W_ONE : low_len;
                    pulses_d   = pulse_count;
                    high_cnt_d = high_len;
                    if ((high_len == W_ZERO) || (pulse_count == C_ZERO)) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_HIGH;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (high_cnt_q <= W_ONE) begin
                    pulses_d = pulses_q - C_ONE;
                    if (pulses_q <= C_ONE) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d   = ST_LOW;
                        low_cnt_d = low_len_q;
                    end
                end else begin
                    high_cnt_d = high_cnt_q - W_ONE;
                end
            end
            ST_LOW: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (low_cnt_q <= W_ONE) begin
                    state_d    = ST_HIGH;
                    high_cnt_d = high_len_q;
                end else begin
                    low_cnt_d = low_cnt_q - W_ONE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the flops line up with the state they describe.
        pulse_out_d = (state_d == ST_HIGH);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FINISH);
    end

    // State, latched train parameters, counters and output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            high_len_q  <= W_ZERO;
            low_len_q   <= W_ZERO;
            pulses_q    <= C_ZERO;
            high_cnt_q  <= W_ZERO;
            low_cnt_q   <= W_ZERO;
            pulse_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            high_len_q  <= high_len_d;
            low_len_q   <= low_len_d;
            pulses_q    <= pulses_d;
            high_cnt_q  <= high_cnt_d;
            low_cnt_q   <= low_cnt_d;
            pulse_out_q <= pulse_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pulse_out = pulse_out_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Randomized self-checking bench for pulse_train_generator against a cycle-list reference model.
module tb_pulse_train_generator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] high_len;
    logic [3:0] low_len;
    logic [3:0] pulse_count;
    logic       pulse_out;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    // Expected {pulse_out, busy, done} for each cycle from T+1 through the done cycle.
    logic [2:0] exp_q[$];
    int         exp_pulses;

    always #5 clk = ~clk;

    pulse_train_generator #(.WIDTH_W(4), .COUNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .high_len    (high_len),
        .low_len     (low_len),
        .pulse_count (pulse_count),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done)
    );

    task automatic build_expected(input int h, input int l, input int n);
        int gap;
        exp_q.delete();
        gap = (l == 0) ? 1 : l;
        if (h == 0 || n == 0) begin
            exp_pulses = 0;
            exp_q.push_back(3'b011);
        end else begin
            exp_pulses = n;
            for (int p = 1; p <= n; p++) begin
                for (int c = 0; c < h; c++) exp_q.push_back(3'b110);
                if (p < n) begin
                    for (int c = 0; c < gap; c++) exp_q.push_back(3'b010);
                end
            end
            exp_q.push_back(3'b011);
        end
    endtask

    // Present a start at a negedge; returns at the negedge of cycle T+1.
    task automatic launch(input int h, input int l, input int n, input logic ab, input logic scramble);
        @(negedge clk);
        high_len    = 4'(h);
        low_len     = 4'(l);
        pulse_count = 4'(n);
        abort       = ab;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        if (scramble) begin
            high_len    = 4'($urandom_range(0, 15));
            low_len     = 4'($urandom_range(0, 15));
            pulse_count = 4'($urandom_range(0, 15));
        end
        build_expected(h, l, n);
    endtask

    // Walk exp_q from the current negedge; optional abort after cycle index abort_at.
    // Ends at the negedge of the first cycle after the train, having checked it idle.
    task automatic check_expected(input string name, input int abort_at);
        int   seen;
        logic prev;
        seen = 0;
        prev = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if ({pulse_out, busy, done} !== exp_q[i]) begin
                errors++;
                $display("FAIL %s cycle %0d: {pulse_out,busy,done} got %b expected %b",
                         name, i + 1, {pulse_out, busy, done}, exp_q[i]);
            end
            if (pulse_out && !prev) seen++;
            prev = pulse_out;
            if (i == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                checks++;
                if ({pulse_out, busy, done} !== 3'b000) begin
                    errors++;
                    $display("FAIL %s_abort: got %b expected 000", name, {pulse_out, busy, done});
                end
                return;
            end
            @(negedge clk);
        end
        checks++;
        if ({pulse_out, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL %s_idle_after: got %b expected 000", name, {pulse_out, busy, done});
        end
        checks++;
        if (seen != exp_pulses) begin
            errors++;
            $display("FAIL %s_pulse_count: detected %0d expected %0d", name, seen, exp_pulses);
        end
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            checks++;
            if ({pulse_out, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected 000", name, i, {pulse_out, busy, done});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        high_len = 4'd3; low_len = 4'd2; pulse_count = 4'd2;
        #12;
        checks++;
        if ({pulse_out, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: got %b expected 000", {pulse_out, busy, done});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset_no_pulses", 5);
    endtask

    task automatic test_fixed();
        launch(1, 2, 3, 1'b0, 1'b1);
        check_expected("h1_l2_n3", -1);
        launch(3, 0, 2, 1'b0, 1'b1);
        check_expected("h3_l0_n2", -1);
        launch(15, 15, 15, 1'b0, 1'b1);
        check_expected("max_all", -1);
        launch(15, 0, 1, 1'b0, 1'b1);
        check_expected("max_high_single", -1);
    endtask

    task automatic test_zero();
        launch(0, 5, 3, 1'b0, 1'b1);
        check_expected("zero_high", -1);
        launch(4, 2, 0, 1'b0, 1'b1);
        check_expected("zero_count", -1);
        launch(0, 0, 0, 1'b0, 1'b1);
        check_expected("zero_all", -1);
    endtask

    task automatic test_start_held();
        @(negedge clk);
        high_len = 4'd2; low_len = 4'd1; pulse_count = 4'd2;
        start = 1'b1;
        @(negedge clk);
        high_len = 4'd1; low_len = 4'd0; pulse_count = 4'd1;
        build_expected(2, 1, 2);
        check_expected("held_first", -1);
        @(negedge clk);
        start = 1'b0;
        build_expected(1, 0, 1);
        check_expected("held_second", -1);
        check_idle("held_no_third", 3);
    endtask

    task automatic test_abort();
        launch(4, 3, 5, 1'b0, 1'b1);
        check_expected("abort_2nd_high", 1);
        check_idle("abort_no_done", 4);
        launch(2, 1, 2, 1'b1, 1'b1);
        check_expected("abort_idle_start_wins", -1);
    endtask

    task automatic test_async_reset();
        launch(3, 2, 4, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({pulse_out, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset_immediate: got %b expected 000", {pulse_out, busy, done});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("async_reset_after", 6);
        launch(1, 1, 2, 1'b0, 1'b1);
        check_expected("after_async_reset", -1);
    endtask

    task automatic test_random();
        int h, l, n, ab;
        for (int k = 0; k < 25; k++) begin
            h = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 5));
            l = int'($urandom_range(0, 4));
            n = int'($urandom_range(0, 5));
            launch(h, l, n, 1'b0, 1'b1);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, exp_q.size() - 1)) : -1;
            check_expected($sformatf("rand%0d_h%0d_l%0d_n%0d", k, h, l, n), ab);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_zero();
        test_start_held();
        test_abort();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
